pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, replacing the fixed-field inter-stage registers of the miniCPU pipeline (first user: ID/EX). It carries N operand words that can each be overridden by forwarded data at capture time, a generic payload and a control bundle. It supports downstream back-pressure (stall), flush (bubble insertion) and an optional skid entry that registers the upstream ready. A saturating counter reports how many live beats flushes have killed.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_stage_slot.sv | 68 ++++++
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths for the miniCPU inter-stage registers: operand defaults,
// control-bundle field layout (LSB first) and the ID/EX payload breakdown.
// Also holds the saturating adder used by the kill counter.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_OPND_DEF = 2;

  // Control bundle fields, packed LSB first.
  localparam int RAM_WE_W     = 1;
  localparam int ALUB_SEL_W   = 2;
  localparam int ALU_OP_W     = 4;
  localparam int RF_WE_W      = 1;
  localparam int BRANCH_W     = 3;
  localparam int RF_WSEL_W    = 2;
  localparam int RAM_WE_LSB   = 0;
  localparam int ALUB_SEL_LSB = RAM_WE_LSB + RAM_WE_W;
  localparam int ALU_OP_LSB   = ALUB_SEL_LSB + ALUB_SEL_W;
  localparam int RF_WE_LSB    = ALU_OP_LSB + ALU_OP_W;
  localparam int BRANCH_LSB   = RF_WE_LSB + RF_WE_W;
  localparam int RF_WSEL_LSB  = BRANCH_LSB + BRANCH_W;
  localparam int CTRL_W       = RF_WSEL_LSB + RF_WSEL_W;   // 13

  // ID/EX payload: {wR, pc, pc4, imm, have_inst}.
  localparam int WR_W        = 5;
  localparam int PC_W        = 32;
  localparam int PC4_W       = 32;
  localparam int IMM_W       = 31;
  localparam int HAVE_INST_W = 1;
  localparam int PAYLOAD_W   = WR_W + PC_W + PC4_W + IMM_W + HAVE_INST_W;  // 101

  // 8-bit add of a small increment that sticks at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage entry of a pipeline stage: valid bit plus operand/payload/ctrl.
// Latency: loads on the rising edge after ld_i. Backpressure: none, the owner decides.
// Ports: zero_i clears everything (flush), ld_i loads and sets valid,
// inv_i drops valid but keeps the data. Priority zero_i > ld_i > inv_i.
module pipe_stage_slot import pipe_pkg::*; #(
  parameter int OPND_W = DATA_W_DEF * N_OPND_DEF,
  parameter int PL_W   = PAYLOAD_W,
  parameter int CT_W   = CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              zero_i,
  input  logic              ld_i,
  input  logic              inv_i,
  input  logic [OPND_W-1:0] opnd_i,
  input  logic [PL_W-1:0]   payload_i,
  input  logic [CT_W-1:0]   ctrl_i,
  output logic              vld_o,
  output logic [OPND_W-1:0] opnd_o,
  output logic [PL_W-1:0]   payload_o,
  output logic [CT_W-1:0]   ctrl_o
);

  logic              vld_d, vld_q;
  logic [OPND_W-1:0] opnd_d, opnd_q;
  logic [PL_W-1:0]   payload_d, payload_q;
  logic [CT_W-1:0]   ctrl_d, ctrl_q;

  always_comb begin
    vld_d     = vld_q;
    opnd_d    = opnd_q;
    payload_d = payload_q;
    ctrl_d    = ctrl_q;
    if (zero_i) begin
      vld_d     = 1'b0;
      opnd_d    = '0;
      payload_d = '0;
      ctrl_d    = '0;
    end else if (ld_i) begin
      vld_d     = 1'b1;
      opnd_d    = opnd_i;
      payload_d = payload_i;
      ctrl_d    = ctrl_i;
    end else if (inv_i) begin
      vld_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= 1'b0;
      opnd_q    <= '0;
      payload_q <= '0;
      ctrl_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      opnd_q    <= opnd_d;
      payload_q <= payload_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign vld_o     = vld_q;
  assign opnd_o    = opnd_q;
  assign payload_o = payload_q;
  assign ctrl_o    = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with operand forwarding at capture, flush and kill counter.
// Latency: 1 cycle accept -> dn_valid_o; 1 beat/cycle while dn_ready_i=1.
// Backpressure: up_ready_o = ~dn_valid_o | dn_ready_i, or with PIPE_STAGE_SKID_EN a registered
// ready backed by a skid entry (low only when both entries are full).
// Ports: up_* beat in (operand k at [k*DATA_W +: DATA_W]), fwd_en_i/fwd_data_i per-operand
// override, flush_i kills all held/entering beats, dn_* registered beat out,
// flush_cnt_o saturating count of killed beats.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_OPND    = N_OPND_DEF,
  parameter int PAYLOAD_W = pipe_pkg::PAYLOAD_W,
  parameter int CTRL_W    = pipe_pkg::CTRL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     up_valid_i,
  output logic                     up_ready_o,
  input  logic [N_OPND*DATA_W-1:0] up_opnd_i,
  input  logic [PAYLOAD_W-1:0]     up_payload_i,
  input  logic [CTRL_W-1:0]        up_ctrl_i,
  input  logic [N_OPND-1:0]        fwd_en_i,
  input  logic [N_OPND*DATA_W-1:0] fwd_data_i,
  input  logic                     flush_i,
  output logic                     dn_valid_o,
  input  logic                     dn_ready_i,
  output logic [N_OPND*DATA_W-1:0] dn_opnd_o,
  output logic [PAYLOAD_W-1:0]     dn_payload_o,
  output logic [CTRL_W-1:0]        dn_ctrl_o,
  output logic [7:0]               flush_cnt_o
);

  localparam int OPND_W = N_OPND * DATA_W;

  logic              accept, consume;
  logic              out_vld, skd_vld;
  logic              out_ld, out_inv;
  logic [OPND_W-1:0] cap_opnd;
  logic [OPND_W-1:0] src_opnd;
  logic [PAYLOAD_W-1:0] src_payload;
  logic [CTRL_W-1:0] src_ctrl;

  assign accept  = up_valid_i & up_ready_o;
  assign consume = out_vld & dn_ready_i;

  // Forwarding only touches the beat being captured; stored beats are never rewritten.
  always_comb begin
    cap_opnd = up_opnd_i;
    for (int k = 0; k < N_OPND; k++) begin
      if (fwd_en_i[k]) cap_opnd[k*DATA_W +: DATA_W] = fwd_data_i[k*DATA_W +: DATA_W];
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic                 skd_ld, skd_inv;
  logic [OPND_W-1:0]    skd_opnd;
  logic [PAYLOAD_W-1:0] skd_payload;
  logic [CTRL_W-1:0]    skd_ctrl;

  // State is {out_vld, skd_vld}: EMPTY=00, ONE=10, TWO=11. Ready comes straight from a flop.
  assign up_ready_o = ~skd_vld;

  always_comb begin
    // Output refills from skid when it holds the older beat, else from the input.
    src_opnd    = skd_vld ? skd_opnd    : cap_opnd;
    src_payload = skd_vld ? skd_payload : up_payload_i;
    src_ctrl    = skd_vld ? skd_ctrl    : up_ctrl_i;
    out_ld      = consume ? (skd_vld | accept) : (accept & ~out_vld);
    out_inv     = consume & ~skd_vld & ~accept;
    skd_ld      = accept & out_vld & ~consume;
    skd_inv     = consume & skd_vld;
  end

  pipe_stage_slot #(.OPND_W(OPND_W), .PL_W(PAYLOAD_W), .CT_W(CTRL_W)) u_skd (
    .clk       (clk),
    .rst_n     (rst_n),
    .zero_i    (flush_i),
    .ld_i      (skd_ld),
    .inv_i     (skd_inv),
    .opnd_i    (cap_opnd),
    .payload_i (up_payload_i),
    .ctrl_i    (up_ctrl_i),
    .vld_o     (skd_vld),
    .opnd_o    (skd_opnd),
    .payload_o (skd_payload),
    .ctrl_o    (skd_ctrl)
  );
`else
  assign skd_vld     = 1'b0;
  assign up_ready_o  = ~out_vld | dn_ready_i;
  assign out_ld      = accept;
  assign out_inv     = consume;
  assign src_opnd    = cap_opnd;
  assign src_payload = up_payload_i;
  assign src_ctrl    = up_ctrl_i;
`endif

  pipe_stage_slot #(.OPND_W(OPND_W), .PL_W(PAYLOAD_W), .CT_W(CTRL_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .zero_i    (flush_i),
    .ld_i      (out_ld),
    .inv_i     (out_inv),
    .opnd_i    (src_opnd),
    .payload_i (src_payload),
    .ctrl_i    (src_ctrl),
    .vld_o     (out_vld),
    .opnd_o    (dn_opnd_o),
    .payload_o (dn_payload_o),
    .ctrl_o    (dn_ctrl_o)
  );

  assign dn_valid_o = out_vld;

  // An output beat taken by downstream in the flush cycle was delivered, not killed.
  logic [1:0] kill_n;
  logic [7:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    kill_n      = 2'(out_vld & ~dn_ready_i) + 2'(skd_vld) + 2'(accept);
    flush_cnt_d = flush_cnt_q;
    if (flush_i) flush_cnt_d = sat_add8(flush_cnt_q, kill_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_cnt_q <= 8'd0;
    else        flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based model checked every cycle plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int NO = 2;
  localparam int OW = DW * NO;
  localparam int PW = pipe_pkg::PAYLOAD_W;
  localparam int CW = pipe_pkg::CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int K1 = SKID ? 2 : 1;   // beats killed by a flush of a full, non-accepting stage

  logic          clk, rst_n;
  logic          up_valid_i, up_ready_o;
  logic [OW-1:0] up_opnd_i, fwd_data_i, dn_opnd_o;
  logic [PW-1:0] up_payload_i, dn_payload_o;
  logic [CW-1:0] up_ctrl_i, dn_ctrl_o;
  logic [NO-1:0] fwd_en_i;
  logic          flush_i, dn_valid_o, dn_ready_i;
  logic [7:0]    flush_cnt_o;

  pipe_stage_reg #(.DATA_W(DW), .N_OPND(NO), .PAYLOAD_W(PW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
    .up_opnd_i(up_opnd_i), .up_payload_i(up_payload_i), .up_ctrl_i(up_ctrl_i),
    .fwd_en_i(fwd_en_i), .fwd_data_i(fwd_data_i), .flush_i(flush_i),
    .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
    .dn_opnd_o(dn_opnd_o), .dn_payload_o(dn_payload_o), .dn_ctrl_o(dn_ctrl_o),
    .flush_cnt_o(flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an ordered queue of held beats ----------------
  typedef struct packed {
    logic [OW-1:0] opnd;
    logic [PW-1:0] pl;
    logic [CW-1:0] ctrl;
  } beat_t;

  beat_t q[$];
  int    m_cnt = 0;

  function automatic bit model_ready();
    return SKID ? (q.size() < 2) : (q.size() == 0 || dn_ready_i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit    acc, cons;
      int    killed;
      beat_t b;
      acc  = up_valid_i && model_ready();
      cons = (q.size() > 0) && dn_ready_i;
      b.opnd = up_opnd_i;
      for (int k = 0; k < NO; k++)
        if (fwd_en_i[k]) b.opnd[k*DW +: DW] = fwd_data_i[k*DW +: DW];
      b.pl   = up_payload_i;
      b.ctrl = up_ctrl_i;
      if (flush_i) begin
        killed = q.size() - (cons ? 1 : 0) + (acc ? 1 : 0);
        m_cnt  = (m_cnt + killed > 255) ? 255 : m_cnt + killed;
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc)  q.push_back(b);
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("m_dn_valid", dn_valid_o, (q.size() > 0));
    chk("m_up_ready", up_ready_o, model_ready());
    chk("m_flush_cnt", flush_cnt_o, m_cnt);
    if (q.size() > 0) begin
      chk("m_opnd", dn_opnd_o, q[0].opnd);
      chk("m_payload", dn_payload_o, q[0].pl);
      chk("m_ctrl", dn_ctrl_o, q[0].ctrl);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_beat(input logic v, input logic [31:0] s);
    logic [PW-1:0] pl;
    up_valid_i = v;
    for (int k = 0; k < NO; k++) up_opnd_i[k*DW +: DW] = s + 32'(k * 32'h1000);
    pl = '0;
    pl[31:0] = s;
    pl[PW-1 -: 32] = ~s;
    up_payload_i = pl;
    up_ctrl_i = CW'(s * 5);
    fwd_en_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; up_valid_i = 1'b0; up_opnd_i = '0; up_payload_i = '0; up_ctrl_i = '0;
    fwd_en_i = '0; fwd_data_i = '0; flush_i = 1'b0; dn_ready_i = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_dn_valid", dn_valid_o, 0);
    chk("rst_opnd", dn_opnd_o, 0);
    chk("rst_payload", dn_payload_o, 0);
    chk("rst_ctrl", dn_ctrl_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);
    chk("rst_up_ready", up_ready_o, 1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", up_ready_o, 1);
    step();

    // Stream 10 beats at full rate
    for (int i = 0; i < 10; i++) begin
      set_beat(1'b1, 32'h100 + i);
      @(negedge clk);
      chk("stream_ready", up_ready_o, 1);
      if (i > 0) chk("stream_opnd0", dn_opnd_o[DW-1:0], 32'h100 + i - 1);
      step();
    end
    up_valid_i = 1'b0;
    @(negedge clk);
    chk("stream_last_vld", dn_valid_o, 1);
    chk("stream_last_opnd0", dn_opnd_o[DW-1:0], 32'h109);

    // Forwarding on operand 0 only
    step();
    set_beat(1'b1, 32'h11);
    up_opnd_i[DW +: DW] = 32'h22;
    fwd_en_i = 2'b01;
    fwd_data_i = {32'hBB, 32'hAA};
    step();
    up_valid_i = 1'b0;
    fwd_en_i = '0;
    @(negedge clk);
    chk("fwd_vld", dn_valid_o, 1);
    chk("fwd_opnd0", dn_opnd_o[DW-1:0], 32'hAA);
    chk("fwd_opnd1", dn_opnd_o[DW +: DW], 32'h22);

    // Stall: downstream not ready while A, B, C are offered
    step();
    dn_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      set_beat(1'b1, 32'h200 + acc);
      @(negedge clk);
      if (up_ready_o) acc++;
      step();
    end
    set_beat(1'b1, 32'h200 + acc);
    @(negedge clk);
    chk("stall_accepted", acc, K1);
    chk("stall_ready", up_ready_o, 0);
    chk("stall_head", dn_opnd_o[DW-1:0], 32'h200);

    // Flush a full stage (C still offered, not accepted)
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    up_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_vld", dn_valid_o, 0);
    chk("flush_ctrl", dn_ctrl_o, 0);
    chk("flush_opnd", dn_opnd_o, 0);
    chk("flush_payload", dn_payload_o, 0);
    chk("flush_cnt_full", flush_cnt_o, K1);

    // Flush one held beat while a new beat is offered
    step();
    set_beat(1'b1, 32'h300);
    step();
    set_beat(1'b1, 32'h301);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    up_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_cnt_one_acc", flush_cnt_o, 2 * K1);

    // Flush coinciding with consume: nothing counted
    step();
    set_beat(1'b1, 32'h400);
    step();
    up_valid_i = 1'b0;
    dn_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_consume_cnt", flush_cnt_o, 2 * K1);
    chk("flush_consume_vld", dn_valid_o, 0);

    // 300 flushes each killing one accepted beat -> saturation
    step();
    dn_ready_i = 1'b0;
    flush_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_beat(1'b1, 32'h600 + i);
      step();
      if (i == 99) chk("sat_mid", flush_cnt_o, 2 * K1 + 100);
    end
    flush_i = 1'b0;
    up_valid_i = 1'b0;
    @(negedge clk);
    chk("sat_cnt", flush_cnt_o, 255);

    // Asynchronous reset in the middle of a stall
    step();
    set_beat(1'b1, 32'h700);
    step();
    set_beat(1'b1, 32'h701);
    step();
    up_valid_i = 1'b0;
    chk("pre_areset_vld", dn_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_vld", dn_valid_o, 0);
    chk("areset_opnd", dn_opnd_o, 0);
    chk("areset_payload", dn_payload_o, 0);
    chk("areset_ctrl", dn_ctrl_o, 0);
    chk("areset_cnt", flush_cnt_o, 0);
    chk("areset_ready", up_ready_o, 1);
    step();
    rst_n = 1'b1;

    // Mixed traffic with per-operand forwarding and toggling back-pressure
    dn_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b1, 32'h800 + i);
      fwd_en_i = NO'(i);
      fwd_data_i = {32'hF0 + i, 32'hE0 + i};
      step();
    end
    up_valid_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      set_beat(1'($urandom_range(0, 1)), 32'h900 + i);
      fwd_en_i = NO'($urandom_range(0, 3));
      fwd_data_i = {32'hC000 + i, 32'hD000 + i};
      dn_ready_i = 1'($urandom_range(0, 1));
      flush_i = ($urandom_range(0, 15) == 0);
      step();
    end
    up_valid_i = 1'b0;
    flush_i = 1'b0;
    dn_ready_i = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
